// File: rtl/elixirchip_es1_spu_op_diff.sv
// SPU difference operator: m = x - prev (or prev - x) with carry-in/out, the
// inverse of the SPU accumulator, followed by a LATENCY-1 stage output pipeline.
module elixirchip_es1_spu_op_diff #(
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned S_DATA_BITS = 8,
    parameter type         s_data_t    = logic [S_DATA_BITS-1:0],
    parameter int unsigned M_DATA_BITS = 8,
    parameter type         m_data_t    = logic [M_DATA_BITS-1:0],
    parameter m_data_t     CLEAR_DATA  = '0,
    parameter logic        CLEAR_CARRY = 1'b0,
    parameter string       DEVICE      = "RTL",
    parameter string       SIMULATION  = "false",
    parameter string       DEBUG       = "false"
) (
    input  logic    reset,
    input  logic    clk,
    input  logic    cke,

    input  logic    s_sub,
    input  logic    s_carry,
    input  s_data_t s_data,
    input  logic    s_clear,
    input  logic    s_valid,

    output logic    m_carry,
    output m_data_t m_data,
    output logic    m_valid
);

    localparam bit IS_XILINX = (DEVICE == "ULTRASCALE")
                            || (DEVICE == "ULTRASCALE_PLUS")
                            || (DEVICE == "ULTRASCALE_PLUS_ES1")
                            || (DEVICE == "ULTRASCALE_PLUS_ES2");
    // In simulation the plain adder is used unless DEBUG asks for the chain model.
    localparam bit USE_CARRY_CHAIN = IS_XILINX && (M_DATA_BITS > 3)
                                  && ((SIMULATION != "true") || (DEBUG == "true"));

    m_data_t x;
    m_data_t prev;
    m_data_t op_a;
    m_data_t op_b;
    logic [M_DATA_BITS:0] sum;

    assign x    = m_data_t'(s_data);
    assign op_a = s_sub ? prev : x;
    assign op_b = s_sub ? x    : prev;

    if (USE_CARRY_CHAIN) begin : g_carry_chain
        m_data_t              sel;
        m_data_t              o;
        logic [M_DATA_BITS:0] cy;

        assign sel = op_a ^ ~op_b;

        // Propagate/generate mux chain, same structure as the carry8 slice.
        always_comb begin
            cy    = '0;
            o     = '0;
            cy[0] = s_carry;
            for (int unsigned i = 0; i < M_DATA_BITS; i++) begin
                o[i]    = sel[i] ^ cy[i];
                cy[i+1] = sel[i] ? cy[i] : op_a[i];
            end
        end

        assign sum = {cy[M_DATA_BITS], o};
    end else begin : g_rtl_adder
        assign sum = {1'b0, op_a} + {1'b0, ~op_b} + {{M_DATA_BITS{1'b0}}, s_carry};
    end

    m_data_t st0_data;
    logic    st0_carry;
    logic    st0_valid;

    always_ff @(posedge clk) begin
        if (reset || s_clear) begin
            prev      <= CLEAR_DATA;
            st0_data  <= CLEAR_DATA;
            st0_carry <= CLEAR_CARRY;
            st0_valid <= 1'b0;
        end else if (cke) begin
            if (s_valid) begin
                st0_data  <= sum[M_DATA_BITS-1:0];
                st0_carry <= sum[M_DATA_BITS];
                prev      <= x;
            end
            st0_valid <= s_valid;
        end
    end

    if (LATENCY > 1) begin : g_pipe
        localparam int unsigned N = LATENCY - 1;

        logic [N-1:0] pv;
        logic [N-1:0] pc;
        m_data_t      pd [N];

        // s_clear deliberately does not reach here: in-flight samples still emerge.
        always_ff @(posedge clk) begin
            if (reset) begin
                pv <= '0;
                pc <= {N{CLEAR_CARRY}};
                for (int unsigned i = 0; i < N; i++) begin
                    pd[i] <= CLEAR_DATA;
                end
            end else if (cke) begin
                pv[0] <= st0_valid;
                pc[0] <= st0_carry;
                pd[0] <= st0_data;
                for (int unsigned i = 1; i < N; i++) begin
                    pv[i] <= pv[i-1];
                    pc[i] <= pc[i-1];
                    pd[i] <= pd[i-1];
                end
            end
        end

        assign m_valid = pv[N-1];
        assign m_carry = pc[N-1];
        assign m_data  = pd[N-1];
    end else begin : g_direct
        assign m_valid = st0_valid;
        assign m_carry = st0_carry;
        assign m_data  = st0_data;
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_diff.sv
// Bench for elixirchip_es1_spu_op_diff: directed vector table, random model checks,
// clear/cke sequences, accumulator-inverse stream and a LATENCY=4 pipeline scoreboard.
module tb_elixirchip_es1_spu_op_diff;

    logic        clk;
    logic        reset;
    logic        cke;
    logic        s_sub;
    logic        s_carry;
    logic [7:0]  s_data;
    logic [11:0] s_data12;
    logic        s_clear;
    logic        s_valid;

    logic       a_carry, b_carry, c_carry, d_carry, e_carry;
    logic [7:0] a_data,  b_data,  c_data,  d_data,  e_data;
    logic       a_valid, b_valid, c_valid, d_valid, e_valid;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: LATENCY=1, CLEAR_DATA=0
    elixirchip_es1_spu_op_diff #(.LATENCY(1)) u_a (
        .reset(reset), .clk(clk), .cke(cke), .s_sub(s_sub), .s_carry(s_carry),
        .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
        .m_carry(a_carry), .m_data(a_data), .m_valid(a_valid));

    // B: LATENCY=1, CLEAR_DATA=0x10, CLEAR_CARRY=1
    elixirchip_es1_spu_op_diff #(.LATENCY(1), .CLEAR_DATA(8'h10), .CLEAR_CARRY(1'b1)) u_b (
        .reset(reset), .clk(clk), .cke(cke), .s_sub(s_sub), .s_carry(s_carry),
        .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
        .m_carry(b_carry), .m_data(b_data), .m_valid(b_valid));

    // C: LATENCY=4
    elixirchip_es1_spu_op_diff #(.LATENCY(4)) u_c (
        .reset(reset), .clk(clk), .cke(cke), .s_sub(s_sub), .s_carry(s_carry),
        .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
        .m_carry(c_carry), .m_data(c_data), .m_valid(c_valid));

    // D/E: 12-bit input truncated to 8-bit arithmetic, RTL vs carry-chain path
    elixirchip_es1_spu_op_diff #(.S_DATA_BITS(12), .M_DATA_BITS(8), .DEVICE("RTL")) u_d (
        .reset(reset), .clk(clk), .cke(cke), .s_sub(s_sub), .s_carry(s_carry),
        .s_data(s_data12), .s_clear(s_clear), .s_valid(s_valid),
        .m_carry(d_carry), .m_data(d_data), .m_valid(d_valid));

    elixirchip_es1_spu_op_diff #(.S_DATA_BITS(12), .M_DATA_BITS(8), .DEVICE("ULTRASCALE_PLUS")) u_e (
        .reset(reset), .clk(clk), .cke(cke), .s_sub(s_sub), .s_carry(s_carry),
        .s_data(s_data12), .s_clear(s_clear), .s_valid(s_valid),
        .m_carry(e_carry), .m_data(e_data), .m_valid(e_valid));

    typedef struct packed {
        logic       sub;
        logic       cin;
        logic [7:0] x;
        logic [7:0] d;
        logic       c;
    } vec_t;

    vec_t vt [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_clear = 1'b0;
        s_valid = 1'b0;
        cke     = 1'b0;
        step();
        step();
        reset   = 1'b0;
    endtask

    // Reference difference: (x - prev) or (prev - x), minus 1 when carry-in is 0.
    function automatic logic [8:0] ref_diff(input logic sub, input logic cin,
                                            input logic [7:0] x, input logic [7:0] p);
        int dd;
        dd = sub ? (int'(p) - int'(x)) : (int'(x) - int'(p));
        if (!cin) dd = dd - 1;
        ref_diff = {(dd >= 0), dd[7:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev_m;
        logic [7:0] acc;
        logic [7:0] inc;
        logic [8:0] r;
        // LATENCY=4 scoreboard state
        logic       m0_v, m0_c;
        logic [7:0] m0_d, mp;
        logic       pv [3];
        logic       pc [3];
        logic [7:0] pd [3];
        logic       clr;

        vt[0]  = '{1'b0, 1'b1, 8'h05, 8'h05, 1'b1};
        vt[1]  = '{1'b0, 1'b1, 8'h0C, 8'h07, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 8'h0C, 8'h00, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 8'h03, 8'hF7, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 8'h20, 8'h1D, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 8'h30, 8'hF0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 8'h20, 8'hF0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 8'h30, 8'hEF, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 8'h30, 8'hFF, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 8'h35, 8'h04, 1'b1};
        vt[10] = '{1'b1, 1'b1, 8'h05, 8'h30, 1'b1};
        vt[11] = '{1'b0, 1'b1, 8'hFF, 8'hFA, 1'b1};
        vt[12] = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b0};

        s_sub = 1'b0; s_carry = 1'b1; s_data = '0; s_data12 = '0;
        do_reset();

        chk("rst_a_data",  32'(a_data),  32'h00);
        chk("rst_a_carry", 32'(a_carry), 32'h0);
        chk("rst_a_valid", 32'(a_valid), 32'h0);
        chk("rst_b_data",  32'(b_data),  32'h10);
        chk("rst_b_carry", 32'(b_carry), 32'h1);
        chk("rst_c_data",  32'(c_data),  32'h00);
        chk("rst_c_valid", 32'(c_valid), 32'h0);

        // Directed table; odd rows put a nonzero upper nibble on the 12-bit input.
        cke = 1'b1;
        for (int i = 0; i < 13; i++) begin
            s_sub    = vt[i].sub;
            s_carry  = vt[i].cin;
            s_data   = vt[i].x;
            s_data12 = {((i % 2) == 1) ? 4'h1 : 4'hE, vt[i].x};
            s_valid  = 1'b1;
            step();
            chk($sformatf("vec%0d_a_data", i),  32'(a_data),  32'(vt[i].d));
            chk($sformatf("vec%0d_a_carry", i), 32'(a_carry), 32'(vt[i].c));
            chk($sformatf("vec%0d_a_valid", i), 32'(a_valid), 32'h1);
            chk($sformatf("vec%0d_d_data", i),  32'(d_data),  32'(vt[i].d));
            chk($sformatf("vec%0d_d_carry", i), 32'(d_carry), 32'(vt[i].c));
            chk($sformatf("vec%0d_e_data", i),  32'(e_data),  32'(vt[i].d));
            chk($sformatf("vec%0d_e_carry", i), 32'(e_carry), 32'(vt[i].c));
        end

        // Random sub/carry/data against the arithmetic reference.
        prev_m = 8'h00;
        for (int i = 0; i < 30; i++) begin
            s_sub    = 1'($urandom);
            s_carry  = 1'($urandom);
            s_data   = 8'($urandom);
            s_data12 = {4'($urandom), s_data};
            r = ref_diff(s_sub, s_carry, s_data, prev_m);
            step();
            chk("rnd_a", 32'({a_carry, a_data}), 32'(r));
            chk("rnd_d", 32'({d_carry, d_data}), 32'(r));
            chk("rnd_e", 32'({e_carry, e_data}), 32'(r));
            prev_m = s_data;
        end

        // Clear with cke low drops the concurrent sample.
        s_sub = 1'b0; s_carry = 1'b1;
        cke = 1'b0; s_clear = 1'b1; s_valid = 1'b1; s_data = 8'h09;
        step();
        s_clear = 1'b0;
        chk("clr_b_valid", 32'(b_valid), 32'h0);
        chk("clr_b_data",  32'(b_data),  32'h10);
        chk("clr_b_carry", 32'(b_carry), 32'h1);
        chk("clr_a_data",  32'(a_data),  32'h00);
        cke = 1'b1; s_data = 8'h04;
        step();
        chk("clr_next_b_data",  32'(b_data),  32'hF4);
        chk("clr_next_b_carry", 32'(b_carry), 32'h0);
        chk("clr_next_a_data",  32'(a_data),  32'h04);
        cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_data = 8'($urandom);
            s_sub  = 1'($urandom);
            step();
            chk("ckelo_b_data",  32'(b_data),  32'hF4);
            chk("ckelo_b_valid", 32'(b_valid), 32'h1);
        end
        cke = 1'b1; s_valid = 1'b0; s_sub = 1'b0;
        step();
        chk("gap_b_valid", 32'(b_valid), 32'h0);
        chk("gap_b_data",  32'(b_data),  32'hF4);

        // Accumulator inverse: feed running sums, expect the increments back.
        s_clear = 1'b1;
        step();
        s_clear = 1'b0;
        acc = 8'h10;
        for (int i = 0; i < 24; i++) begin
            inc     = 8'($urandom);
            acc     = acc + inc;
            s_data  = acc;
            s_valid = 1'b1;
            step();
            chk("inv_b_data",  32'(b_data),  32'(inc));
            chk("inv_b_valid", 32'(b_valid), 32'h1);
        end

        // LATENCY=4: random cke, valid gaps and occasional clear.
        do_reset();
        m0_v = 1'b0; m0_c = 1'b0; m0_d = '0; mp = '0;
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0; pc[k] = 1'b0; pd[k] = '0;
        end
        s_sub = 1'b0; s_carry = 1'b1;
        for (int i = 0; i < 80; i++) begin
            cke     = ($urandom_range(0, 3) != 0);
            s_valid = ($urandom_range(0, 2) != 0);
            clr     = ($urandom_range(0, 15) == 0);
            s_clear = clr;
            s_data  = 8'($urandom);
            if (cke) begin
                pv[2] = pv[1]; pc[2] = pc[1]; pd[2] = pd[1];
                pv[1] = pv[0]; pc[1] = pc[0]; pd[1] = pd[0];
                pv[0] = m0_v;  pc[0] = m0_c;  pd[0] = m0_d;
            end
            if (clr) begin
                m0_v = 1'b0; m0_c = 1'b0; m0_d = '0; mp = '0;
            end else if (cke) begin
                if (s_valid) begin
                    r = ref_diff(1'b0, 1'b1, s_data, mp);
                    m0_c = r[8];
                    m0_d = r[7:0];
                    mp   = s_data;
                end
                m0_v = s_valid;
            end
            step();
            chk("l4_valid", 32'(c_valid), 32'(pv[2]));
            chk("l4_data",  32'(c_data),  32'(pd[2]));
            chk("l4_carry", 32'(c_carry), 32'(pc[2]));
        end
        s_clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
